// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between the icache and dcache. One transaction is in flight at a time.
// dcache has fixed priority, and a bounded streak counter guarantees that icache makes progress.
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate
);

  localparam int SW = $clog2(MAX_D_STREAK) + 1;
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
  localparam logic [1:0] RAM_ACCESS = 2'd2;

  typedef enum logic [1:0] {IDLE, DGRANT, IGRANT} state_t;

  state_t        state, state_nxt, arb_state;
  logic [SW-1:0] streak, streak_nxt;
  logic          dreq, ireq, access;

  assign dreq   = dREN | dWEN;
  assign ireq   = iREN;
  assign access = (ramstate == RAM_ACCESS);
  assign iload  = ramload;
  assign dload  = ramload;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      streak <= '0;
    end else begin
      state  <= state_nxt;
      streak <= streak_nxt;
    end
  end

  always_comb begin
    streak_nxt = streak;
    if (!ireq)
      streak_nxt = '0;
    else if (state == DGRANT && access)
      streak_nxt = (streak == STREAK_MAX) ? streak : streak + 1'b1;
    else if (state == IGRANT && access)
      streak_nxt = '0;
  end

  // Arbitrate on the post-update streak so that the MAX_D_STREAK-th dcache completion hands over directly
  always_comb begin
    if (ireq && (streak_nxt == STREAK_MAX || !dreq))
      arb_state = IGRANT;
    else if (dreq)
      arb_state = DGRANT;
    else
      arb_state = IDLE;
  end

  always_comb begin
    state_nxt = state;
    iwait     = 1'b1;
    dwait     = 1'b1;
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    ramaddr   = '0;
    ramstore  = '0;
    case (state)
      IDLE: state_nxt = arb_state;
      DGRANT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        dwait    = ~access;
        if (access)     state_nxt = arb_state;
        else if (!dreq) state_nxt = IDLE;
      end
      IGRANT: begin
        ramaddr = iaddr;
        ramREN  = 1'b1;
        iwait   = ~access;
        if (access)     state_nxt = arb_state;
        else if (!ireq) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed vector bench for mem_arbiter: a per-cycle stimulus/expectation table, followed by a
// hand-written sequence that asserts reset in the middle of a transaction.
module tb_mem_arbiter;

  localparam logic [1:0] F = 2'd0, B = 2'd1, A = 2'd2, E = 2'd3;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramREN, ramWEN;
  logic [31:0] iload, dload, ramaddr, ramstore;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        dr, dw;
    logic [31:0] da, ds;
    logic [1:0]  rs;
    logic [31:0] rl;
    logic        e_iw, e_dw, e_ren, e_wen;
    logic [31:0] e_addr, e_store;
  } vec_t;

  vec_t vecs[$];

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  function automatic vec_t mk(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                              input logic [31:0] da, input logic [31:0] ds, input logic [1:0] rs,
                              input logic [31:0] rl, input logic eiw, input logic edw,
                              input logic eren, input logic ewen, input logic [31:0] ea,
                              input logic [31:0] es);
    vec_t v;
    v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.ds = ds; v.rs = rs; v.rl = rl;
    v.e_iw = eiw; v.e_dw = edw; v.e_ren = eren; v.e_wen = ewen; v.e_addr = ea; v.e_store = es;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got 0x%08h expected 0x%08h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    iREN = v.ir; iaddr = v.ia; dREN = v.dr; dWEN = v.dw;
    daddr = v.da; dstore = v.ds; ramstate = v.rs; ramload = v.rl;
  endtask

  initial begin
    nRST = 1'b0;
    iREN = 0; dREN = 0; dWEN = 0; iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = F;

    // single icache read, BUSY x2 then ACCESS
    vecs.push_back(mk(1, 32'h40, 0, 0, 0, 0, F, 0,            1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h40, 0, 0, 0, 0, B, 0,            1, 1, 1, 0, 32'h40, 0));
    vecs.push_back(mk(1, 32'h40, 0, 0, 0, 0, B, 0,            1, 1, 1, 0, 32'h40, 0));
    vecs.push_back(mk(0, 32'h40, 0, 0, 0, 0, A, 32'hDEADBEEF, 0, 1, 1, 0, 32'h40, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, F, 0,                 1, 1, 0, 0, 0, 0));
    // simultaneous: dcache write first, then icache with no bubble
    vecs.push_back(mk(1, 32'h44, 0, 1, 32'h80, 32'h1234, F, 0,  1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h44, 0, 1, 32'h80, 32'h1234, B, 0,  1, 1, 0, 1, 32'h80, 32'h1234));
    vecs.push_back(mk(1, 32'h44, 0, 0, 32'h80, 32'h1234, A, 32'h77, 1, 0, 0, 0, 32'h80, 32'h1234));
    vecs.push_back(mk(1, 32'h44, 0, 0, 32'h80, 32'h1234, B, 0,  1, 1, 1, 0, 32'h44, 0));
    vecs.push_back(mk(0, 32'h44, 0, 0, 0, 0, A, 32'hCAFE0001,   0, 1, 1, 0, 32'h44, 0));
    // starvation bound: 4 dcache completions, 1 icache, then dcache again
    vecs.push_back(mk(1, 32'h48, 1, 0, 32'h100, 0, A, 0,        1, 1, 0, 0, 0, 0));
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(1, 32'h48, 1, 0, 32'h100, 0, A, 32'hD0 + k, 1, 0, 1, 0, 32'h100, 0));
    vecs.push_back(mk(1, 32'h48, 1, 0, 32'h100, 0, A, 32'h1111, 0, 1, 1, 0, 32'h48, 0));
    vecs.push_back(mk(1, 32'h48, 1, 0, 32'h100, 0, A, 32'h2222, 1, 0, 1, 0, 32'h100, 0));
    vecs.push_back(mk(0, 32'h48, 1, 0, 32'h100, 0, B, 0,        1, 1, 1, 0, 32'h100, 0));
    // ERROR retry x3 then ACCESS
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(0, 0, 1, 0, 32'h100, 0, E, 32'h3 + k,   1, 1, 1, 0, 32'h100, 0));
    vecs.push_back(mk(0, 0, 1, 0, 32'h100, 0, A, 32'h55AA55AA,  1, 0, 1, 0, 32'h100, 0));
    // withdrawal straight after a completion
    vecs.push_back(mk(0, 0, 0, 0, 32'h100, 0, F, 0,             1, 1, 0, 0, 32'h100, 0));
    // streak reaches 3, withdrawal, then the next dcache completion must force icache ahead
    vecs.push_back(mk(1, 32'h4C, 1, 0, 32'h200, 0, F, 0,        1, 1, 0, 0, 0, 0));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(1, 32'h4C, 1, 0, 32'h200, 0, A, 32'hE0 + k, 1, 0, 1, 0, 32'h200, 0));
    vecs.push_back(mk(1, 32'h4C, 1, 0, 32'h200, 0, B, 0,        1, 1, 1, 0, 32'h200, 0));
    vecs.push_back(mk(1, 32'h4C, 0, 0, 32'h200, 0, B, 0,        1, 1, 0, 0, 32'h200, 0));
    vecs.push_back(mk(1, 32'h4C, 1, 0, 32'h200, 0, F, 0,        1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h4C, 1, 0, 32'h200, 0, A, 32'hF0,   1, 0, 1, 0, 32'h200, 0));
    vecs.push_back(mk(1, 32'h4C, 1, 0, 32'h200, 0, B, 0,        1, 1, 1, 0, 32'h4C, 0));
    vecs.push_back(mk(0, 32'h4C, 0, 0, 0, 0, A, 32'h0BADF00D,   0, 1, 1, 0, 32'h4C, 0));
    // dREN and dWEN both high is a write
    vecs.push_back(mk(0, 0, 1, 1, 32'h300, 32'hA5A5, F, 0,      1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 32'h300, 32'hA5A5, B, 0,      1, 1, 0, 1, 32'h300, 32'hA5A5));
    vecs.push_back(mk(0, 0, 0, 0, 32'h300, 32'hA5A5, A, 32'h9,  1, 0, 0, 0, 32'h300, 32'hA5A5));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, F, 0,                   1, 1, 0, 0, 0, 0));

    #1;
    chk("rst_iwait", -1, 32'(iwait), 32'd1);
    chk("rst_dwait", -1, 32'(dwait), 32'd1);
    chk("rst_ramREN", -1, 32'(ramREN), 32'd0);
    chk("rst_ramWEN", -1, 32'(ramWEN), 32'd0);
    chk("rst_ramaddr", -1, ramaddr, 32'd0);
    chk("rst_ramstore", -1, ramstore, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge CLK);
      drive(vecs[i]);
      #1;
      chk("iwait", i, 32'(iwait), 32'(vecs[i].e_iw));
      chk("dwait", i, 32'(dwait), 32'(vecs[i].e_dw));
      chk("ramREN", i, 32'(ramREN), 32'(vecs[i].e_ren));
      chk("ramWEN", i, 32'(ramWEN), 32'(vecs[i].e_wen));
      chk("ramaddr", i, ramaddr, vecs[i].e_addr);
      chk("ramstore", i, ramstore, vecs[i].e_store);
      chk("iload", i, iload, vecs[i].rl);
      chk("dload", i, dload, vecs[i].rl);
    end

    // reset asserted during an active dcache write
    @(negedge CLK);
    dWEN = 1; daddr = 32'h10; dstore = 32'h99; ramstate = F;
    @(negedge CLK);
    ramstate = B;
    #1;
    chk("pre_rst_ramWEN", 100, 32'(ramWEN), 32'd1);
    #1;
    nRST = 1'b0;
    #1;
    chk("mid_rst_ramWEN", 101, 32'(ramWEN), 32'd0);
    chk("mid_rst_dwait", 101, 32'(dwait), 32'd1);
    chk("mid_rst_iwait", 101, 32'(iwait), 32'd1);
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    chk("post_rst_ramWEN", 102, 32'(ramWEN), 32'd0);
    chk("post_rst_ramaddr", 102, ramaddr, 32'd0);
    chk("post_rst_ramstore", 102, ramstore, 32'd0);
    chk("post_rst_dwait", 102, 32'(dwait), 32'd1);
    @(negedge CLK);
    #1;
    chk("regrant_ramWEN", 103, 32'(ramWEN), 32'd1);
    chk("regrant_ramaddr", 103, ramaddr, 32'h10);
    dWEN = 0;
    @(negedge CLK);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Downstream neighbour of the icache/dcache pair. It arbitrates their block-fill, write-back and flush requests onto the single-port RAM.
- One transaction is in flight at a time. The grant is registered and held until RAM completes or the requester withdraws.
- dcache has fixed priority over icache. A bounded streak counter guarantees icache forward progress.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data word width
- MAX_D_STREAK, 4, consecutive dcache completions allowed while icache is waiting before icache is forced ahead

Ports:
- CLK  in  1  clock
- nRST  in  1  reset
- iREN  in  1  icache read request
- iaddr  in  ADDR_W  icache word address
- iwait  out  1  icache stall; low only in the completing cycle
- iload  out  DATA_W  icache read data
- dREN  in  1  dcache read request
- dWEN  in  1  dcache write request
- daddr  in  ADDR_W  dcache word address
- dstore  in  DATA_W  dcache write data
- dwait  out  1  dcache stall; low only in the completing cycle
- dload  out  DATA_W  dcache read data
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  ADDR_W  RAM address
- ramstore  out  DATA_W  RAM write data
- ramload  in  DATA_W  RAM read data
- ramstate  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR

Behaviour:
- Reset nRST, asynchronous, active-low; clock CLK.
- Reset values:
  - state IDLE, streak 0
  - iwait=1, dwait=1
  - ramREN=0, ramWEN=0, ramaddr=0, ramstore=0
- Request definitions:
  - dreq = dREN|dWEN.
  - If dREN and dWEN are both high, the access is a write.
  - ireq = iREN.
- States: IDLE, DGRANT, IGRANT. The grant is a registered state; RAM outputs decode combinationally from state and the granted requester's inputs.
- Arbitration function (used in IDLE, and on completion):
  - If ireq && (streak==MAX_D_STREAK || !dreq): IGRANT.
  - Else if dreq: DGRANT.
  - Else: IDLE.
- IDLE:
  - All RAM enables low; ramaddr/ramstore hold 0; both waits high.
  - Next state = arbitration.
  - Minimum latency from request to grant is 1 cycle.
- DGRANT:
  - ramaddr=daddr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN&!dWEN.
  - dwait = !(ramstate==ACCESS); iwait=1.
  - dload = ramload in every cycle, so it is valid when dwait is low.
- IGRANT:
  - ramaddr=iaddr, ramREN=1, ramWEN=0, ramstore=0.
  - iwait = !(ramstate==ACCESS); dwait=1; iload=ramload.
- Completion (ramstate==ACCESS in a grant state):
  - Next state = arbitration, evaluated on the current inputs, so back-to-back transactions need no idle bubble.
  - A requester still asserting in the completing cycle is treated as a new request.
- BUSY/FREE in a grant state: hold the grant and all outputs.
- ERROR in a grant state:
  - Hold the grant and re-drive the same access; the wait stays high.
  - No error is reported upstream.
- Withdrawal:
  - If the granted requester's request drops before ACCESS, go to IDLE next cycle.
  - No completion is signalled and streak is unchanged.
- Streak counter (width clog2(MAX_D_STREAK)+1):
  - On DGRANT completion with ireq high: streak = streak+1, saturating at MAX_D_STREAK.
  - On IGRANT completion, or any cycle with ireq low: streak = 0.
- Simultaneous first requests from IDLE: dcache wins unless streak is saturated.
- Reset mid-transaction: immediately drop enables and raise both waits; no partial write is guaranteed.
- iload and dload are unregistered copies of ramload. The caches sample them only when their own wait is low.

Test Plan:
- Reset: nRST=0 during an active DGRANT write -> same cycle ramWEN=0, dwait=1, iwait=1; after release, state IDLE with all outputs at reset values.
- Single icache read:
  - Stimulus: iREN=1, iaddr=0x40; ramstate BUSY for 2 cycles then ACCESS with ramload=0xDEADBEEF.
  - Response: ramREN=1 and ramaddr=0x40 from cycle 1; iwait low for exactly 1 cycle with iload=0xDEADBEEF.
- Simultaneous requests:
  - Stimulus: iREN=1 and dWEN=1, daddr=0x80, dstore=0x1234, asserted together.
  - Response: dcache granted first (ramWEN=1, ramstore=0x1234); icache granted on the cycle after dwait pulses, with no IDLE bubble.
- Starvation bound:
  - Stimulus: dREN held high continuously, iREN high, RAM ACCESS every cycle, MAX_D_STREAK=4.
  - Response: exactly 4 dcache completions, then 1 icache completion, then dcache resumes.
- ERROR retry:
  - Stimulus: DGRANT read with ramstate ERROR for 3 cycles, then ACCESS.
  - Response: ramaddr and ramREN stable throughout; dwait low only on the ACCESS cycle.
- Withdrawal:
  - Stimulus: dREN drops in a BUSY cycle while in DGRANT.
  - Response: next cycle IDLE, ramREN=0, dwait never low, streak unchanged.
